// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and
// byte/address widths.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_ADDR_W = 7;
  localparam logic [I2C_ADDR_W-1:0] I2C_GC_ADDR = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one edge-detect register; produces SCL edges,
// START and STOP events and the synchronized SDA level.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda;
  assign stop     = scl_s & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target with valid/ready byte handshakes; never stretches SCL.
// Define I2C_TARGET_GENERAL_CALL_EN to also ACK general-call writes (adds RX_GC).
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  SCL,
  input  logic                  SDA,
  output logic                  SDA_OE,
  output logic [I2C_BYTE_W-1:0] RX_DATA,
  output logic                  RX_VLD,
`ifdef I2C_TARGET_GENERAL_CALL_EN
  output logic                  RX_GC,
`endif
  input  logic                  RX_READY,
  input  logic [I2C_BYTE_W-1:0] TX_DATA,
  input  logic                  TX_VLD,
  output logic                  TX_ACK,
  output logic                  TX_UNDERRUN,
  output logic                  BUSY
);

  i2c_state_e            state;
  logic [2:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shift;
  logic [I2C_BYTE_W-1:0] shift_in;
  logic [I2C_BYTE_W-1:0] tx_byte;
  logic                  rw;
  logic                  ack_phase;
  logic                  sda_s;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_det;
  logic                  stop_det;
  logic                  addr_hit;
  logic                  gc_hit;
  logic                  tx_load;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .scl_raw (SCL),
    .sda_raw (SDA),
    .sda     (sda_s),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start_det),
    .stop    (stop_det)
  );

  assign shift_in = {shift[I2C_BYTE_W-2:0], sda_s};
  assign addr_hit = (shift_in[I2C_BYTE_W-1:1] == TARGET_ADDR);
  assign tx_byte  = TX_VLD ? TX_DATA : '1;

`ifdef I2C_TARGET_GENERAL_CALL_EN
  logic is_gc;
  assign gc_hit = (shift_in[I2C_BYTE_W-1:1] == I2C_GC_ADDR) && !shift_in[0];
`else
  assign gc_hit = 1'b0;
`endif

  // Both the end of the address ACK (read) and the end of a master ACK fetch
  // the next read byte on the same scl_fall, so they share one load path.
  assign tx_load = scl_fall && ack_phase &&
                   ((state == ST_ADDR_ACK && rw) || state == ST_TX_ACK);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      rw          <= 1'b0;
      ack_phase   <= 1'b0;
      SDA_OE      <= 1'b0;
      RX_DATA     <= '0;
      RX_VLD      <= 1'b0;
      TX_ACK      <= 1'b0;
      TX_UNDERRUN <= 1'b0;
      BUSY        <= 1'b0;
`ifdef I2C_TARGET_GENERAL_CALL_EN
      is_gc       <= 1'b0;
      RX_GC       <= 1'b0;
`endif
    end else begin
      RX_VLD      <= 1'b0;
      TX_ACK      <= 1'b0;
      TX_UNDERRUN <= 1'b0;
`ifdef I2C_TARGET_GENERAL_CALL_EN
      RX_GC       <= 1'b0;
`endif
      if (stop_det) begin
        state   <= ST_IDLE;
        SDA_OE  <= 1'b0;
        BUSY    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        SDA_OE  <= 1'b0;
        bit_cnt <= '0;
      end else if (tx_load) begin
        shift       <= {tx_byte[I2C_BYTE_W-2:0], 1'b1};
        SDA_OE      <= ~tx_byte[I2C_BYTE_W-1];
        TX_ACK      <= TX_VLD;
        TX_UNDERRUN <= ~TX_VLD;
        bit_cnt     <= '0;
        state       <= ST_TX_BYTE;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw        <= shift_in[0];
                ack_phase <= 1'b0;
`ifdef I2C_TARGET_GENERAL_CALL_EN
                is_gc     <= gc_hit;
`endif
                if (addr_hit || gc_hit) begin
                  state <= ST_ADDR_ACK;
                  BUSY  <= 1'b1;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                SDA_OE    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                SDA_OE <= 1'b0;
                state  <= ST_RX_BYTE;
              end
            end
          end
          ST_RX_BYTE: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (RX_READY) begin
                  RX_DATA   <= shift_in;
                  RX_VLD    <= 1'b1;
`ifdef I2C_TARGET_GENERAL_CALL_EN
                  RX_GC     <= is_gc;
`endif
                  ack_phase <= 1'b0;
                  state     <= ST_RX_ACK;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_TX_BYTE: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                SDA_OE    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= ST_TX_ACK;
              end else begin
                SDA_OE <= ~shift[I2C_BYTE_W-1];
                shift  <= {shift[I2C_BYTE_W-2:0], 1'b1};
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise) begin
              if (sda_s) state <= ST_WAIT_STOP;
              else       ack_phase <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target; expectations come from a
// transaction-level model of address match, byte acceptance and read data.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int unsigned Q  = 5;
  localparam logic [6:0]  TA = 7'h50;
`ifdef I2C_TARGET_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]      addr;
    logic            rw;
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic [3:0]      rdy;
    logic [3:0]      tvld;
    logic            exp_aack;
  } vec_t;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       SCL = 1'b1;
  logic       m_low = 1'b0;
  logic       SDA;
  logic       SDA_OE;
  logic [7:0] RX_DATA;
  logic       RX_VLD;
  logic       RX_READY = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VLD = 1'b0;
  logic       TX_ACK;
  logic       TX_UNDERRUN;
  logic       BUSY;
`ifdef I2C_TARGET_GENERAL_CALL_EN
  logic       RX_GC;
`endif

  assign SDA = ~(m_low | SDA_OE);

  i2c_target #(
    .TARGET_ADDR(TA),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .SCL        (SCL),
    .SDA        (SDA),
    .SDA_OE     (SDA_OE),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
`ifdef I2C_TARGET_GENERAL_CALL_EN
    .RX_GC      (RX_GC),
`endif
    .RX_READY   (RX_READY),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_ACK     (TX_ACK),
    .TX_UNDERRUN(TX_UNDERRUN),
    .BUSY       (BUSY)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;
  int tx_ack_n = 0;
  int und_n = 0;
  int oe_seen = 0;
  int oe_bad = 0;
  logic [7:0] rx_log[$];
  logic oe_prev = 1'b0;

  always @(negedge PCLK) begin
    if (RX_VLD) rx_log.push_back(RX_DATA);
    if (TX_ACK) tx_ack_n++;
    if (TX_UNDERRUN) und_n++;
    if (SDA_OE) oe_seen++;
    if (PRESETn && SCL && SDA_OE !== oe_prev) oe_bad++;
    oe_prev = SDA_OE;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(negedge PCLK);
  endtask

  task automatic send_start();
    m_low = 1'b0; hq(); SCL = 1'b1; hq(); m_low = 1'b1; hq(); SCL = 1'b0; hq();
  endtask

  task automatic send_stop();
    m_low = 1'b1; hq(); SCL = 1'b1; hq(); m_low = 1'b0; hq();
  endtask

  task automatic wr_bit(input logic b);
    m_low = ~b; hq(); SCL = 1'b1; hq(); hq(); SCL = 1'b0; hq();
  endtask

  task automatic rd_bit(output logic b);
    m_low = 1'b0; hq(); SCL = 1'b1; hq(); b = SDA; hq(); SCL = 1'b0; hq();
  endtask

  task automatic wr_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
  endtask

  task automatic rd_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
  endtask

  function automatic logic addr_match(input logic [6:0] a, input logic rw);
    return (a == TA) || (GC_EN && a == 7'h00 && !rw);
  endfunction

  function automatic vec_t mk(input logic [6:0] a, input logic rw, input logic [2:0] n,
                              input logic [31:0] d, input logic [3:0] rdy,
                              input logic [3:0] tvld, input logic ea);
    vec_t v;
    v.addr = a; v.rw = rw; v.n = n; v.d = d;
    v.rdy = rdy; v.tvld = tvld; v.exp_aack = ea;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input logic exp_aack, input logic do_stop);
    logic       b;
    logic [7:0] got;
    logic [7:0] exp_b;
    logic [7:0] exp_rx[$];
    int rx_base, txa_base, und_base, oe_base, exp_tx, exp_und;
    rx_base = rx_log.size(); txa_base = tx_ack_n; und_base = und_n; oe_base = oe_seen;
    exp_tx = 0; exp_und = 0;
    if (v.rw) begin TX_VLD = v.tvld[0]; TX_DATA = v.d[0]; end
    send_start();
    wr_byte({v.addr, v.rw});
    rd_bit(b);
    chk("addr_ack", 32'(!b), 32'(exp_aack));
    chk("busy_after_addr", 32'(BUSY), 32'(exp_aack));
    if (exp_aack && !v.rw) begin
      for (int i = 0; i < int'(v.n); i++) begin
        RX_READY = v.rdy[i];
        wr_byte(v.d[i]);
        rd_bit(b);
        chk("data_ack", 32'(!b), 32'(v.rdy[i]));
        if (!v.rdy[i]) break;
        exp_rx.push_back(v.d[i]);
      end
    end else if (exp_aack) begin
      for (int i = 0; i < int'(v.n); i++) begin
        rd_byte(got);
        exp_b = v.tvld[i] ? v.d[i] : 8'hFF;
        if (v.tvld[i]) exp_tx++; else exp_und++;
        chk("read_byte", 32'(got), 32'(exp_b));
        if (i < int'(v.n) - 1) begin
          TX_VLD = v.tvld[i+1]; TX_DATA = v.d[i+1];
          wr_bit(1'b0);
        end else begin
          wr_bit(1'b1);
        end
      end
    end
    chk("busy_before_stop", 32'(BUSY), 32'(exp_aack));
    if (do_stop) begin
      send_stop(); hq();
      chk("busy_after_stop", 32'(BUSY), 32'd0);
    end
    chk("rx_count", 32'(rx_log.size() - rx_base), 32'(exp_rx.size()));
    foreach (exp_rx[k])
      if (rx_base + k < rx_log.size()) chk("rx_data", 32'(rx_log[rx_base+k]), 32'(exp_rx[k]));
    if (exp_rx.size() > 0) chk("rx_data_hold", 32'(RX_DATA), 32'(exp_rx[$]));
    chk("tx_ack_count", 32'(tx_ack_n - txa_base), 32'(exp_tx));
    chk("underrun_count", 32'(und_n - und_base), 32'(exp_und));
    if (!exp_aack) chk("no_drive", 32'(oe_seen - oe_base), 32'd0);
    hq();
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    logic [31:0] r;
    logic b;
    int oe_base, rx_base;

    tbl[0] = mk(7'h50, 1'b0, 3'd2, 32'h0000_3CA5, 4'b0011, 4'b0000, 1'b1);
    tbl[1] = mk(7'h51, 1'b0, 3'd2, 32'h0000_3CA5, 4'b0011, 4'b0000, 1'b0);
    tbl[2] = mk(7'h50, 1'b1, 3'd2, 32'h0000_0F96, 4'b0000, 4'b0011, 1'b1);
    tbl[3] = mk(7'h50, 1'b1, 3'd1, 32'h0000_0012, 4'b0000, 4'b0000, 1'b1);
    tbl[4] = mk(7'h00, 1'b0, 3'd1, 32'h0000_005A, 4'b0001, 4'b0000, GC_EN);
    tbl[5] = mk(7'h00, 1'b1, 3'd1, 32'h0000_0033, 4'b0000, 4'b0001, 1'b0);
    tbl[6] = mk(7'h50, 1'b0, 3'd3, 32'h0081_FF00, 4'b0111, 4'b0000, 1'b1);
    tbl[7] = mk(7'h50, 1'b1, 3'd3, 32'h007E_0180, 4'b0000, 4'b0101, 1'b1);

    repeat (3) @(negedge PCLK);
    chk("rst_sda_oe", 32'(SDA_OE), 32'd0);
    chk("rst_rx_data", 32'(RX_DATA), 32'h00);
    chk("rst_rx_vld", 32'(RX_VLD), 32'd0);
    chk("rst_tx_ack", 32'(TX_ACK), 32'd0);
    chk("rst_tx_underrun", 32'(TX_UNDERRUN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    PRESETn = 1'b1;
    hq();

    for (int i = 0; i < 8; i++) do_txn(tbl[i], tbl[i].exp_aack, 1'b1);

    // Second write byte refused, then repeated START into a read.
    do_txn(mk(7'h50, 1'b0, 3'd2, 32'h0000_3CA5, 4'b0001, 4'b0000, 1'b1), 1'b1, 1'b0);
    do_txn(mk(7'h50, 1'b1, 3'd1, 32'h0000_00C3, 4'b0000, 4'b0001, 1'b1), 1'b1, 1'b1);

    // Reset pulse while the target holds the address ACK.
    send_start();
    wr_byte({TA, 1'b0});
    m_low = 1'b0; hq(); SCL = 1'b1; hq();
    chk("ack_driven", 32'(SDA_OE), 32'd1);
    #2 PRESETn = 1'b0;
    #1 chk("reset_async_release", 32'(SDA_OE), 32'd0);
    @(negedge PCLK);
    #2 PRESETn = 1'b1;
    hq(); SCL = 1'b0; hq();
    oe_base = oe_seen; rx_base = rx_log.size();
    wr_byte({TA, 1'b0});
    rd_bit(b);
    chk("ignored_after_reset", 32'(b), 32'd1);
    chk("ignored_busy", 32'(BUSY), 32'd0);
    chk("ignored_no_drive", 32'(oe_seen - oe_base), 32'd0);
    chk("ignored_no_rx", 32'(rx_log.size() - rx_base), 32'd0);
    send_stop(); hq();

    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      case (r[1:0])
        2'd0: v.addr = TA;
        2'd1: v.addr = 7'h51;
        2'd2: v.addr = 7'h00;
        default: begin r = $urandom; v.addr = r[6:0]; end
      endcase
      r = $urandom; v.rw = r[0];
      r = $urandom_range(1, 4); v.n = r[2:0];
      v.d = $urandom;
      r = $urandom | $urandom; v.rdy = r[3:0];
      r = $urandom | $urandom; v.tvld = r[3:0];
      v.exp_aack = addr_match(v.addr, v.rw);
      do_txn(v, v.exp_aack, 1'b1);
    end

    chk("sda_oe_stable_scl_high", 32'(oe_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
